// File: rtl/givens_matrix_loader.sv
// givens_matrix_loader
// Takes one (cos, sin) pair per rotation and writes the 2x2 Givens matrix
// G = [[c, -s], [s, c]] into a 4-word single-port BRAM in row-major order.
// When the write is complete it pulses done for one cycle.
//
// Optional feature macro: GIVENS_READBACK_VERIFY_EN
//   When defined, the four words are read back after the write and compared
//   against what was written. Any difference sets verify_err, which stays set
//   until the next accepted pair clears it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         pair handshake; in_ready is high only in IDLE
//   cos_in, sin_in              signed two's complement inputs
//   ena/wea/addra/dina_givens   BRAM write/read port
//   douta_givens                BRAM read data (used in verify builds only)
//   busy                        high in every state except IDLE
//   done                        one-cycle pulse when the matrix is complete
//   verify_err                  sticky readback mismatch (verify builds only)
module givens_matrix_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] cos_in,
    input  logic [DATA_W-1:0] sin_in,
    output logic              ena_givens,
    output logic              wea_givens,
    output logic [ADDR_W-1:0] addra_givens,
    output logic [DATA_W-1:0] dina_givens,
    input  logic [DATA_W-1:0] douta_givens,
    output logic              busy,
    output logic              done
`ifdef GIVENS_READBACK_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RDBK  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] c_q, s_q, neg_s;
    logic              accept;
    logic              cnt_last;

    assign accept   = (state == S_IDLE) && in_valid;
    // The 2-bit counter wrapping from 3 to 0 is the only end-of-sweep marker.
    assign cnt_last = &cnt;

    // -s with the one unrepresentable case clamped to the most positive value.
    assign neg_s = (s_q == S_MIN) ? ~S_MIN : -s_q;

    function automatic logic [DATA_W-1:0] word_at(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] c,
        input logic [DATA_W-1:0] s,
        input logic [DATA_W-1:0] ns
    );
        if (a == ADDR_W'(1))      return ns;
        else if (a == ADDR_W'(2)) return s;
        else                      return c;
    endfunction

`ifdef GIVENS_READBACK_VERIFY_EN
    // Tracks each issued read until its data appears on douta_givens.
    logic [RD_LATENCY-1:0]             rd_vld;
    logic [RD_LATENCY-1:0][ADDR_W-1:0] rd_addr;
    logic                              chk_now, chk_last, chk_bad;

    assign chk_now  = rd_vld[RD_LATENCY-1];
    assign chk_last = chk_now && (&rd_addr[RD_LATENCY-1]);
    assign chk_bad  = chk_now &&
                      (douta_givens != word_at(rd_addr[RD_LATENCY-1], c_q, s_q, neg_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld     <= '0;
            rd_addr    <= '0;
            verify_err <= 1'b0;
        end else begin
            rd_vld[0]  <= (state == S_RDBK);
            rd_addr[0] <= cnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld[i]  <= rd_vld[i-1];
                rd_addr[i] <= rd_addr[i-1];
            end
            if (accept)       verify_err <= 1'b0;
            else if (chk_bad) verify_err <= 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = (^douta_givens) ^ (RD_LATENCY != 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_WRITE;
`ifdef GIVENS_READBACK_VERIFY_EN
            S_WRITE: if (cnt_last) state_nxt = S_RDBK;
            S_RDBK:  if (cnt_last) state_nxt = S_CHECK;
            S_CHECK: if (chk_last) state_nxt = S_DONE;
`else
            S_WRITE: if (cnt_last) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pair capture and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            s_q <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                c_q <= cos_in;
                s_q <= sin_in;
            end
            if (state == S_WRITE || state == S_RDBK) cnt <= cnt + ADDR_W'(1);
            else                                     cnt <= '0;
        end
    end

    // Outputs. The last word written is always c_q (addr3), so holding c_q
    // outside WRITE keeps dina at its last written value.
    always_comb begin
        in_ready     = (state == S_IDLE);
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        ena_givens   = (state == S_WRITE) || (state == S_RDBK);
        wea_givens   = (state == S_WRITE);
        addra_givens = cnt;
        dina_givens  = c_q;
        if (state == S_WRITE) dina_givens = word_at(cnt, c_q, s_q, neg_s);
    end

endmodule
